// File: rtl/ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifetch_ctrl
//
// Fetch sequencer for a 256x32 instruction memory with asynchronous read.
// It owns the fetch PC, drives the memory with that byte address, captures
// the returned word into a small prefetch FIFO, and hands {pc, instr} to
// decode over a valid/ready handshake. A redirect flushes the FIFO and
// restarts fetch at a new target after one bubble cycle.
//
// Parameters
//   RESET_PC   fetch PC loaded on reset (word aligned)
//   BUF_DEPTH  prefetch FIFO entries (power of 2, >= 2)
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   fetch_en     in   1 = fetching permitted; 0 = PC holds, FIFO drains
//   imem_addr    out  byte address to instruction memory (always fetch_pc)
//   imem_data    in   instruction word for imem_addr, same cycle
//   redirect     in   one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc  in   new fetch target, sampled while redirect=1
//   inst_valid   out  FIFO head valid
//   inst_ready   in   decode accepts the head this cycle
//   inst_pc      out  PC of the head entry
//   inst_data    out  instruction of the head entry
//   fetch_fault  out  misaligned redirect seen (alignment check build only)
//   dbg_state    out  current FSM state encoding (0=RUN, 1=FLUSH, 2=FAULT)
//
// Handshake: an entry moves to decode in every cycle where inst_valid and
// inst_ready are both 1 at the rising edge. While inst_valid=1 and
// inst_ready=0 the head (inst_pc/inst_data) holds steady.
//
// Build option
//   FETCH_ALIGN_CHK_EN  when defined, a redirect whose target is not word
//                       aligned sends the block to a sticky FAULT state that
//                       only reset clears. When undefined, the low two bits
//                       of redirect_pc are dropped and fetch_fault is 0.
// ---------------------------------------------------------------------------
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        fetch_fault,
    output logic [1:0]  dbg_state
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

`ifdef FETCH_ALIGN_CHK_EN
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1
    } state_t;
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      pc_mem   [BUF_DEPTH];
    logic [31:0]      data_mem [BUF_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
`ifdef FETCH_ALIGN_CHK_EN
    logic             fault_q;
`endif

    // -----------------------------------------------------------------------
    // Next-state helpers
    // -----------------------------------------------------------------------
    logic             pop;
    logic             fire;
    logic             take_redirect;
    logic             misaligned;
    logic [31:0]      load_pc;
    logic [PTR_W-1:0] head_next;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      head_pc_next;
    logic [31:0]      head_data_next;

    always_comb begin
        pop = inst_valid & inst_ready;

`ifdef FETCH_ALIGN_CHK_EN
        // Once faulted, redirects are ignored until reset.
        take_redirect = redirect & (state != ST_FAULT);
        misaligned    = |redirect_pc[1:0];
        load_pc       = redirect_pc;
`else
        take_redirect = redirect;
        misaligned    = 1'b0;
        load_pc       = redirect_pc & 32'hFFFF_FFFC;
`endif

        // A full FIFO can still take a new word when the head leaves in the
        // same cycle; this is what sustains one instruction per cycle.
        fire = fetch_en & (state == ST_RUN) & ~redirect &
               ((count < DEPTH_CNT) | pop);

        head_next = pop ? head + 1'b1 : head;

        case ({fire, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase

        // The output registers load whatever will sit at the head after this
        // edge. If that slot is being written right now (FIFO empty, or one
        // entry leaving while one arrives), take the incoming word directly.
        if (fire && (tail == head_next)) begin
            head_pc_next   = fetch_pc;
            head_data_next = imem_data;
        end else begin
            head_pc_next   = pc_mem[head_next];
            head_data_next = data_mem[head_next];
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer, FIFO and registered decode outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            fetch_pc   <= RESET_PC;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            inst_valid <= 1'b0;
            inst_pc    <= 32'h0;
            inst_data  <= 32'h0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_mem[i]   <= 32'h0;
                data_mem[i] <= 32'h0;
            end
`ifdef FETCH_ALIGN_CHK_EN
            fault_q    <= 1'b0;
`endif
        end else if (take_redirect) begin
            // Flush: drop every buffered entry. A pop decode completes in
            // this same cycle is simply absorbed by the flush.
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            inst_valid <= 1'b0;
            fetch_pc   <= load_pc;
`ifdef FETCH_ALIGN_CHK_EN
            if (misaligned) begin
                state   <= ST_FAULT;
                fault_q <= 1'b1;
            end else begin
                state   <= ST_FLUSH;
            end
`else
            state      <= ST_FLUSH;
`endif
        end else begin
            // FIFO bookkeeping runs in every state; fire is only ever high
            // in RUN, and FIFO contents only drain elsewhere.
            if (fire) begin
                pc_mem[tail]   <= fetch_pc;
                data_mem[tail] <= imem_data;
                tail           <= tail + 1'b1;
                fetch_pc       <= fetch_pc + 32'd4;
            end
            head       <= head_next;
            count      <= count_next;
            inst_valid <= (count_next != '0);
            if (count_next != '0) begin
                inst_pc   <= head_pc_next;
                inst_data <= head_data_next;
            end

            case (state)
                ST_RUN:   state <= ST_RUN;
                ST_FLUSH: state <= ST_RUN;   // single bubble after redirect
`ifdef FETCH_ALIGN_CHK_EN
                ST_FAULT: state <= ST_FAULT; // sticky until reset
`endif
                default:  state <= ST_RUN;
            endcase
        end
    end

    assign imem_addr = fetch_pc;
    assign dbg_state = state;

`ifdef FETCH_ALIGN_CHK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifetch_ctrl
//
// Directed bench for ifetch_ctrl with default parameters (RESET_PC=0,
// BUF_DEPTH=2). The memory model holds mem[i] = i + 0x100 and is read
// combinationally at imem_addr[9:2]. Inputs change 1 ns after a rising edge
// and outputs are sampled at that same point, so every value seen reflects
// the edge just taken.
// ---------------------------------------------------------------------------
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        fetch_fault;
    logic [1:0]  dbg_state;

    logic [31:0] mem [256];
    logic [31:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    // -----------------------------------------------------------------------
    // Clock / reset / memory model
    // -----------------------------------------------------------------------
    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[9:2]];

    ifetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_pc     (inst_pc),
        .inst_data   (inst_data),
        .fetch_fault (fetch_fault),
        .dbg_state   (dbg_state)
    );

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges; rst_n is still low on return.
    task automatic hold_reset(input logic en, input logic rdy);
        rst_n       = 1'b0;
        fetch_en    = en;
        inst_ready  = rdy;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect    = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        hold_reset(1'b1, 1'b1);
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0h want 0", inst_valid); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", inst_pc); end
        n_cmp++; if (inst_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", inst_data); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %0h want 0", fetch_fault); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    endtask

    task automatic test_stream();
        hold_reset(1'b1, 1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %0h want 1", k, inst_valid); end
            n_cmp++; if (inst_pc !== 32'(4 * k)) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", k, inst_pc, 32'(4 * k)); end
            n_cmp++; if (inst_data !== 32'(256 + k)) begin n_err++; $display("FAIL stream_data[%0d] got %h want %h", k, inst_data, 32'(256 + k)); end
        end
    endtask

    task automatic test_backpressure();
        hold_reset(1'b1, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step();
        n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL bp_addr_stop got %h want 8", imem_addr); end
        n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %0h want 1", inst_valid); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL bp_head_pc got %h want 0", inst_pc); end
        n_cmp++; if (inst_data !== 32'h100) begin n_err++; $display("FAIL bp_head_data got %h want 100", inst_data); end
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
        inst_ready = 1'b1;
        while (exp_q.size() != 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL bp_drain_valid got %0h want 1 (pc %h)", inst_valid, e); end
            n_cmp++; if (inst_pc !== e) begin n_err++; $display("FAIL bp_drain_pc got %h want %h", inst_pc, e); end
            n_cmp++; if (inst_data !== (e >> 2) + 32'h100) begin n_err++; $display("FAIL bp_drain_data got %h want %h", inst_data, (e >> 2) + 32'h100); end
            step();
        end
    endtask

    task automatic test_fetch_en();
        hold_reset(1'b0, 1'b1);
        rst_n = 1'b1;
        step(); step(); step();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL fen_idle_valid got %0h want 0", inst_valid); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL fen_idle_addr got %h want 0", imem_addr); end
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        step(); step(); step();
        fetch_en   = 1'b0;
        inst_ready = 1'b1;
        n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL fen_head0 got %h want 0", inst_pc); end
        step();
        n_cmp++; if (inst_pc !== 32'h4 || inst_valid !== 1'b1) begin n_err++; $display("FAIL fen_head1 got pc %h v %0h want 4/1", inst_pc, inst_valid); end
        step();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL fen_drained got %0h want 0", inst_valid); end
        n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL fen_hold_addr got %h want 8", imem_addr); end
    endtask

    task automatic test_redirect_full();
        hold_reset(1'b1, 1'b0);
        rst_n = 1'b1;
        step(); step(); step();
        inst_ready = 1'b1;
        pulse_redirect(32'h40);
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_r1 got %0h want 0", inst_valid); end
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL rd_addr got %h want 40", imem_addr); end
        n_cmp++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL rd_state got %0d want 1", dbg_state); end
        step();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rd_bubble got %0h want 0", inst_valid); end
        step();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_data !== 32'h110) begin n_err++; $display("FAIL rd_first got v %0h pc %h d %h want 1/40/110", inst_valid, inst_pc, inst_data); end
        step();
        n_cmp++; if (inst_pc !== 32'h44 || inst_data !== 32'h111) begin n_err++; $display("FAIL rd_second got pc %h d %h want 44/111", inst_pc, inst_data); end
    endtask

    task automatic test_back_to_back();
        pulse_redirect(32'h40);
        pulse_redirect(32'h80);
        n_cmp++; if (inst_valid !== 1'b0 || imem_addr !== 32'h80) begin n_err++; $display("FAIL b2b_r2 got v %0h addr %h want 0/80", inst_valid, imem_addr); end
        step();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL b2b_bubble got %0h want 0", inst_valid); end
        step();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80 || inst_data !== 32'h120) begin n_err++; $display("FAIL b2b_first got v %0h pc %h d %h want 1/80/120", inst_valid, inst_pc, inst_data); end
    endtask

    task automatic test_pc_wrap();
        pulse_redirect(32'hFFFF_FFF8);
        step();
        step();
        n_cmp++; if (inst_pc !== 32'hFFFF_FFF8 || inst_data !== 32'h1FE) begin n_err++; $display("FAIL wrap0 got pc %h d %h want fffffff8/1fe", inst_pc, inst_data); end
        step();
        n_cmp++; if (inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'h1FF) begin n_err++; $display("FAIL wrap1 got pc %h d %h want fffffffc/1ff", inst_pc, inst_data); end
        step();
        n_cmp++; if (inst_pc !== 32'h0 || inst_data !== 32'h100) begin n_err++; $display("FAIL wrap2 got pc %h d %h want 0/100", inst_pc, inst_data); end
    endtask

    task automatic test_misaligned();
        pulse_redirect(32'h42);
`ifdef FETCH_ALIGN_CHK_EN
        n_cmp++; if (fetch_fault !== 1'b1 || dbg_state !== 2'd2) begin n_err++; $display("FAIL mis_fault got f %0h st %0d want 1/2", fetch_fault, dbg_state); end
        pulse_redirect(32'h80);
        step(); step();
        n_cmp++; if (inst_valid !== 1'b0 || imem_addr !== 32'h42) begin n_err++; $display("FAIL mis_stuck got v %0h addr %h want 0/42", inst_valid, imem_addr); end
        rst_n = 1'b0;
        step();
        n_cmp++; if (fetch_fault !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL mis_clear got f %0h st %0d want 0/0", fetch_fault, dbg_state); end
        rst_n = 1'b1;
`else
        n_cmp++; if (imem_addr !== 32'h40 || fetch_fault !== 1'b0) begin n_err++; $display("FAIL mis_align got addr %h f %0h want 40/0", imem_addr, fetch_fault); end
        step();
        step();
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_data !== 32'h110) begin n_err++; $display("FAIL mis_resume got v %0h pc %h d %h want 1/40/110", inst_valid, inst_pc, inst_data); end
`endif
    endtask

    task automatic test_reset_override();
        hold_reset(1'b1, 1'b1);
        rst_n = 1'b1;
        step(); step(); step();
        rst_n       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect    = 1'b0;
        n_cmp++; if (imem_addr !== 32'h0 || inst_valid !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_ovr got addr %h v %0h st %0d want 0/0/0", imem_addr, inst_valid, dbg_state); end
        rst_n = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Sequence and report
    // -----------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i + 256);
        test_reset();
        test_stream();
        test_backpressure();
        test_fetch_en();
        test_redirect_full();
        test_back_to_back();
        test_pc_wrap();
        test_misaligned();
        test_reset_override();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
